// File: rtl/reconfig_mac_acc.sv
`default_nettype none
// ============================================================================
//  Module   : reconfig_mac_acc
//  Purpose  : Frame accumulator that sits behind the reconfigurable constant
//             multiplier. It sums up to FRAME_LEN unsigned products per frame
//             into a wide accumulator. It then presents the frame sum, the
//             frame mode, the beat count and status flags on an output
//             valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W     width of an incoming product (multiplier output y)
//    ACC_W      accumulator / result width, must be > DATA_W
//    FRAME_LEN  products per frame, 2..256
//
//  Ports
//    clk        in   1       system clock, rising edge
//    rst_n      in   1       asynchronous active-low reset
//    in_valid   in   1       product beat valid
//    in_ready   out  1       block accepts a beat this cycle
//    in_data    in   DATA_W  product (unsigned)
//    in_mode    in   1       multiplier select used to make in_data
//    in_last    in   1       beat closes the current frame early
//    out_valid  out  1       frame result valid
//    out_ready  in   1       downstream accepts the result
//    out_data   out  ACC_W   frame sum
//    out_mode   out  1       mode latched on the first beat of the frame
//    out_count  out  9       beats in the frame (1..FRAME_LEN)
//    out_mixed  out  1       in_mode changed within the frame
//    out_ovf    out  1       accumulator carried out within the frame
//
//  Build option
//    RECONFIG_MAC_ACC_SAT_EN  when defined, a carry out clamps the
//                             accumulator to all-ones for the rest of the
//                             frame instead of wrapping. out_ovf is set in
//                             both builds.
// ============================================================================
module reconfig_mac_acc #(
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_mode,
  output logic [8:0]        out_count,
  output logic              out_mixed,
  output logic              out_ovf
);

  // Index of the beat that closes a full frame.
  localparam logic [8:0] C_CNT_LAST = 9'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [8:0]        r_cnt;
  logic              r_mode;
  logic              r_mixed;
  logic              r_ovf;

  logic              w_beat;
  logic              w_first;
  logic              w_close;
  logic [ACC_W-1:0]  w_data_ext;
  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_mode_next;
  logic              w_mixed_next;
  logic              w_ovf_next;
  logic [8:0]        w_cnt_inc;

  // Only the ACC state takes beats. HOLD is the one-cycle-minimum bubble
  // while the result waits for the downstream handshake.
  assign in_ready   = (r_state == ST_ACC);
  assign w_beat     = in_valid && in_ready;
  assign w_first    = (r_cnt == 9'd0);
  assign w_cnt_inc  = r_cnt + 9'd1;

  // A frame closes on its FRAME_LEN-th beat or on an early in_last.
  // in_last on the final beat changes nothing.
  assign w_close    = w_beat && ((r_cnt == C_CNT_LAST) || in_last);

  assign w_data_ext = {{(ACC_W-DATA_W){1'b0}}, in_data};
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_data_ext};
  assign w_carry    = w_sum[ACC_W];

`ifdef RECONFIG_MAC_ACC_SAT_EN
  // Once clamped, any non-zero addend carries again. A zero addend leaves
  // all-ones unchanged, so the clamp holds to the end of the frame.
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // The first beat of a frame restarts the sticky flags and latches the
  // mode. Later beats only accumulate into the flags.
  assign w_mode_next  = w_first ? in_mode : r_mode;
  assign w_mixed_next = w_first ? 1'b0 : (r_mixed | (in_mode != r_mode));
  assign w_ovf_next   = (w_first ? 1'b0 : r_ovf) | w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACC;
      r_acc     <= '0;
      r_cnt     <= 9'd0;
      r_mode    <= 1'b0;
      r_mixed   <= 1'b0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
      out_count <= 9'd0;
      out_mixed <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_beat) begin
            r_mode  <= w_mode_next;
            r_mixed <= w_mixed_next;
            r_ovf   <= w_ovf_next;
            if (w_close) begin
              // The closing beat is folded into the published result.
              // The running sum is discarded in the same cycle.
              out_data  <= w_acc_next;
              out_count <= w_cnt_inc;
              out_mode  <= w_mode_next;
              out_mixed <= w_mixed_next;
              out_ovf   <= w_ovf_next;
              out_valid <= 1'b1;
              r_acc     <= '0;
              r_cnt     <= 9'd0;
              r_state   <= ST_HOLD;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_HOLD: begin
          // The out_* registers keep their values after the handshake.
          // They change only when the next frame closes.
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_ACC;
          end
        end
        default: begin
          r_state <= ST_ACC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
